// File: rtl/seg7_pkg.sv
// Shared types, constants and glyph table for the multiplexed 7-segment scanner.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs; element 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : seg7_pkg

// File: rtl/seg7_scan_if.sv
// Nibble load port and display drive signals of the 7-segment scanner.
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 4
);

  logic [4*DIGITS-1:0] data;
  logic                data_load;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                frame_start;

  modport master (
    output data,
    output data_load,
    input  an,
    input  seg,
    input  frame_start
  );

  modport slave (
    input  data,
    input  data_load,
    output an,
    output seg,
    output frame_start
  );

endinterface : seg7_scan_if

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_c_o
);

  assign seg_c_o = SEG_GLYPH[nib_i];

endmodule : hex_to_seg7

// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-segment driver with blanking gaps and frame-aligned shadow update.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  localparam int unsigned DATA_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = cnt_width(TICK_DIV, BLANK_CYC);
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   pending_q, pending_d;
  logic                pend_vld_q, pend_vld_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                fs_q, fs_d;
  logic                boundary;
  logic [3:0]          nib;
  logic [6:0]          glyph;

  // Scan sequencing, frame boundary detection and pending/shadow handoff.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    boundary   = 1'b0;

    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRIVE: begin
        if (cnt_q == TICK_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase

    if (boundary && pend_vld_q) begin
      shadow_d   = pending_q;
      pend_vld_d = 1'b0;
    end

    // A load on the boundary cycle lands in pending after the old value moved to shadow.
    if (bus.data_load) begin
      pending_d  = bus.data;
      pend_vld_d = 1'b1;
    end
  end

  assign nib = 4'(shadow_d >> {idx_d, 2'b00});

  hex_to_seg7 u_dec (
    .nib_i   (nib),
    .seg_c_o (glyph)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic lz_zero;
  assign lz_zero = ((shadow_d >> {idx_d, 2'b00}) == '0);
`endif

  // Output values are derived from next-state so the registers line up with state_q.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    fs_d  = boundary;

    if (state_d == DRIVE) begin
      an_d  = ~(DIGITS'(1) << idx_d);
      seg_d = glyph;
`ifdef SEG7_LZ_BLANK_EN
      if ((idx_d != '0) && lz_zero) begin
        an_d  = '1;
        seg_d = SEG_OFF;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BLANK;
      idx_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      an_q       <= '1;
      seg_q      <= SEG_OFF;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      fs_q       <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = fs_q;

endmodule : seg7_scan

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with DIGITS=4, TICK_DIV=4, BLANK_CYC=1 (20-cycle frame).
module tb_seg7_scan;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned BLANK_CYC = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan #(
    .DIGITS    (DIGITS),
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e, input logic fs_e);
    n_chk++;
    assert ({bus.an, bus.seg, bus.frame_start} === {an_e, seg_e, fs_e})
    else begin
      n_fail++;
      $error("FAIL %s: got an=%b seg=%h fs=%b, expected an=%b seg=%h fs=%b",
             tag, bus.an, bus.seg, bus.frame_start, an_e, seg_e, fs_e);
    end
  endtask

  // Walks frame positions first_s..19; position 5*d is the blank before digit d.
  // lz marks digits that leading-zero blanking must suppress; la/lb are load positions.
  task automatic frame_chk(input string tag,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] lz, input logic fs_first, input int first_s,
                           input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb);
    logic [6:0] segs [4];
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    segs[3] = s3;
    for (int s = first_s; s < 20; s++) begin
      int d;
      int p;
      logic [3:0] an_e;
      logic [6:0] seg_e;
      logic       fs_e;
      d = s / 5;
      p = s % 5;
      if (s == la) begin
        bus.data      = va;
        bus.data_load = 1'b1;
      end else if (s == lb) begin
        bus.data      = vb;
        bus.data_load = 1'b1;
      end else begin
        bus.data_load = 1'b0;
      end
      step();
      bus.data_load = 1'b0;
      an_e  = 4'hF;
      seg_e = 7'h7F;
      fs_e  = (s == 0) ? fs_first : 1'b0;
      if (p != 0) begin
        an_e[d] = 1'b0;
        seg_e   = segs[d];
`ifdef SEG7_LZ_BLANK_EN
        if (lz[d]) begin
          an_e  = 4'hF;
          seg_e = 7'h7F;
        end
`endif
      end
      chk($sformatf("%s_pos%0d", tag, s), an_e, seg_e, fs_e);
    end
  endtask

  initial begin
    bus.data      = '0;
    bus.data_load = 1'b0;

    // Reset forced asynchronously, before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 4'hF, 7'h7F, 1'b0);
    repeat (2) step();
    chk("rst_hold", 4'hF, 7'h7F, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_exit_blank", 4'hF, 7'h7F, 1'b0);

    // Frame 0 shows zeros; 0x1234 loaded mid-frame must not tear.
    frame_chk("f0_zero", 7'h40, 7'h40, 7'h40, 7'h40, 4'b1110, 1'b0, 1, 10, 16'h1234, -1, 16'h0);
    frame_chk("f1_1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 1'b1, 0, -1, 16'h0, -1, 16'h0);
    // Two loads in one frame: last one wins.
    frame_chk("f2_1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 1'b1, 0, 3, 16'hAAAA, 12, 16'hF00F);
    frame_chk("f3_f00f", 7'h0E, 7'h40, 7'h40, 7'h0E, 4'b0000, 1'b1, 0, 5, 16'h1111, -1, 16'h0);
    // Load exactly on the boundary cycle while 0x1111 is pending.
    frame_chk("f4_1111", 7'h79, 7'h79, 7'h79, 7'h79, 4'b0000, 1'b1, 0, 0, 16'h5555, -1, 16'h0);
    frame_chk("f5_5555", 7'h12, 7'h12, 7'h12, 7'h12, 4'b0000, 1'b1, 0, -1, 16'h0, -1, 16'h0);

    // Async reset in the middle of a DRIVE window.
    step();
    chk("f6_start", 4'hF, 7'h7F, 1'b1);
    step();
    chk("f6_drive0", 4'b1110, 7'h12, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_drive", 4'hF, 7'h7F, 1'b0);
    repeat (2) step();
    chk("rst_mid_hold", 4'hF, 7'h7F, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst2_exit_blank", 4'hF, 7'h7F, 1'b0);
    frame_chk("f7_zero", 7'h40, 7'h40, 7'h40, 7'h40, 4'b1110, 1'b0, 1, 7, 16'h0070, -1, 16'h0);
    frame_chk("f8_0070", 7'h40, 7'h78, 7'h40, 7'h40, 4'b1100, 1'b1, 0, -1, 16'h0, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_seg7_scan
